// File: rtl/smart_room_pkg.sv
// Shared keypad definitions: special key codes, blank digit value and entry state encoding.
package smart_room_pkg;

    localparam logic [3:0] KEY_BACKSPACE = 4'hB;
    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] BLANK_DIGIT   = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter: counts enabled cycles since the last restart and flags the final one.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!enable || restart || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/keypad_entry.sv
// Assembles keypad digits into a four-digit candidate code, blank until complete.
// Optional inactivity timeout is built when ENTRY_TIMEOUT_EN is defined.
module keypad_entry
    import smart_room_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic [3:0] ipass0,
    output logic [3:0] ipass1,
    output logic [3:0] ipass2,
    output logic [3:0] ipass3,
    output logic       entry_valid,
    output logic       entry_done,
    output logic [2:0] digit_count,
    output logic       timed_out
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("keypad_entry: TIMEOUT_CYCLES must be at least 2");
    end

    entry_state_e state_q;
    logic [3:0]   buf_q   [4];
    logic [3:0]   ipass_q [4];
    logic [2:0]   cnt_q;
    logic         entry_valid_q;
    logic         entry_done_q;
    logic         timed_out_q;

    logic key_digit_c;
    logic accept_c;
    logic expire_c;
    logic timeout_c;

    assign key_digit_c = is_digit(key);
    assign accept_c    = key_valid && (key_digit_c || key == KEY_BACKSPACE || key == KEY_CLEAR);

`ifdef ENTRY_TIMEOUT_EN
    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != IDLE),
        .restart(accept_c),
        .expire (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // An accepted key on the expiry cycle takes priority over the timeout.
    assign timeout_c = expire_c && !accept_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            entry_valid_q <= 1'b0;
            entry_done_q  <= 1'b0;
            timed_out_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i]   <= BLANK_DIGIT;
                ipass_q[i] <= BLANK_DIGIT;
            end
        end else begin
            entry_done_q <= 1'b0;
            timed_out_q  <= 1'b0;
            if (timeout_c || (accept_c && key == KEY_CLEAR)) begin
                state_q       <= IDLE;
                cnt_q         <= 3'd0;
                entry_valid_q <= 1'b0;
                timed_out_q   <= timeout_c;
                for (int i = 0; i < 4; i++) begin
                    buf_q[i]   <= BLANK_DIGIT;
                    ipass_q[i] <= BLANK_DIGIT;
                end
            end else if (accept_c) begin
                case (state_q)
                    IDLE: begin
                        if (key_digit_c) begin
                            buf_q[0] <= key;
                            cnt_q    <= 3'd1;
                            state_q  <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (key_digit_c) begin
                            buf_q[cnt_q[1:0]] <= key;
                            cnt_q             <= cnt_q + 3'd1;
                            if (cnt_q == 3'd3) begin
                                ipass_q[0]    <= buf_q[0];
                                ipass_q[1]    <= buf_q[1];
                                ipass_q[2]    <= buf_q[2];
                                ipass_q[3]    <= key;
                                entry_valid_q <= 1'b1;
                                entry_done_q  <= 1'b1;
                                state_q       <= READY;
                            end
                        end else begin
                            buf_q[cnt_q[1:0] - 2'd1] <= BLANK_DIGIT;
                            cnt_q                    <= cnt_q - 3'd1;
                            if (cnt_q == 3'd1) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    READY: begin
                        entry_valid_q <= 1'b0;
                        state_q       <= COLLECT;
                        for (int i = 0; i < 4; i++) begin
                            ipass_q[i] <= BLANK_DIGIT;
                        end
                        if (key_digit_c) begin
                            buf_q[0] <= key;
                            buf_q[1] <= BLANK_DIGIT;
                            buf_q[2] <= BLANK_DIGIT;
                            buf_q[3] <= BLANK_DIGIT;
                            cnt_q    <= 3'd1;
                        end else begin
                            buf_q[3] <= BLANK_DIGIT;
                            cnt_q    <= 3'd3;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign ipass0      = ipass_q[0];
    assign ipass1      = ipass_q[1];
    assign ipass2      = ipass_q[2];
    assign ipass3      = ipass_q[3];
    assign entry_valid = entry_valid_q;
    assign entry_done  = entry_done_q;
    assign digit_count = cnt_q;
    assign timed_out   = timed_out_q;

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Collects BCD digit keystrokes from the room keypad scanner and assembles them into a four-digit candidate code for the door unlock comparator. It drives ipass0..ipass3 and holds them stable only when a complete code has been entered. Between entries, every digit output is a non-digit blank value, so a partial entry can never match a stored password. The block supports backspace and clear keys, plus an optional inactivity timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000: number of idle clock cycles before a partial or ready entry is discarded. Minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- key  input  4  key code: 0–9 digit, 4'hB backspace, 4'hC clear, all others ignored
- key_valid  input  1  one-cycle strobe; key is sampled when high
- ipass0  output  4  first entered digit; 4'hF when blank
- ipass1  output  4  second entered digit; 4'hF when blank
- ipass2  output  4  third entered digit; 4'hF when blank
- ipass3  output  4  fourth entered digit; 4'hF when blank
- entry_valid  output  1  high while a complete four-digit code is presented
- entry_done  output  1  one-cycle pulse when the fourth digit is accepted
- digit_count  output  3  digits currently buffered (0–4)
- timed_out  output  1  one-cycle pulse when an entry is discarded by timeout

## Operation
- State machine has three states:
  - IDLE: count 0.
  - COLLECT: count 1–3.
  - READY: count 4.
- Digits go into an internal buffer, buf0..buf3, in entry order. ipass outputs are published only on the transition into READY.
- In IDLE:
  - A digit stores into buf0, sets count to 1, and goes to COLLECT.
  - Backspace, clear and ignored codes have no effect.
- In COLLECT:
  - A digit stores into buf[count] and increments count.
  - When count reaches 4: copy buf to ipass0..3, set entry_valid, pulse entry_done, go to READY.
  - Backspace blanks buf[count-1] and decrements count. It goes to IDLE if count becomes 0.
  - Clear blanks the buffer, sets count to 0, and goes to IDLE.
- In READY:
  - A digit sets ipass0..3 to 4'hF and drops entry_valid. The buffer restarts with that digit (count 1, state COLLECT).
  - Backspace sets ipass to 4'hF and drops entry_valid. Count becomes 3 (buf0..2 kept), state COLLECT.
  - Clear sets ipass to 4'hF, drops entry_valid, sets count 0, and goes to IDLE.
- key_valid with an ignored code changes nothing, including the timeout counter.
- Reset mid-entry discards everything immediately.

## Timing
- Reset values:
  - ipass0..3 = 4'hF; buffer = 4'hF.
  - entry_valid = 0; entry_done = 0; timed_out = 0.
  - digit_count = 0; state IDLE; timeout counter 0.
- All outputs are registered. A key sampled at edge N is reflected after edge N (latency 1).
- entry_done and entry_valid assert after the same edge that latches ipass. ipass never changes while entry_valid is high.
- ipass0..3 are updated together on a single edge. Downstream never sees a mixed old/new code.
- Reset overrides key_valid in the same cycle.
- Back-to-back key_valid strobes on consecutive cycles are each processed.

## Configuration
- ENTRY_TIMEOUT_EN, when defined:
  - In COLLECT or READY, the counter increments each cycle without an accepted key.
  - Every accepted key (digit, backspace, clear) zeroes the counter.
  - When the counter reaches TIMEOUT_CYCLES-1, the next edge performs the clear action and pulses timed_out.
  - If an accepted key arrives on that same cycle, the key wins and no timeout occurs.
  - In IDLE the counter is held at 0.
- ENTRY_TIMEOUT_EN undefined:
  - No counter logic is built.
  - timed_out is tied to 0.
  - Entries persist indefinitely.

## Structure
- Shared package smart_room_pkg holds:
  - KEY_BACKSPACE = 4'hB, KEY_CLEAR = 4'hC, BLANK_DIGIT = 4'hF.
  - The entry state encoding (IDLE, COLLECT, READY).
- Sub-module entry_timer holds the inactivity counter. It is instantiated only under ENTRY_TIMEOUT_EN.
  - Ports: clk, rst, enable, restart, expire.
  - Counter width: $clog2(TIMEOUT_CYCLES).

## Test plan
- Keys 1,2,3,4 → ipass0..3 = 1,2,3,4 after the 4th strobe's edge; entry_done pulses once; entry_valid = 1; digit_count = 4.
- Keys 5,6,B,7,8,9 → ipass = 5,7,8,9; ipass stays 4'hF until the final digit.
- Complete code 1,2,3,4, then key 9 → ipass = F,F,F,F; entry_valid = 0; digit_count = 1. Then C → digit_count = 0, state IDLE.
- rst asserted after keys 3,3 with key_valid high → all outputs at reset values with no clock edge; a subsequent key 3 starts at count 1.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES = 8, key 4 then 8 idle cycles → timed_out pulses, digit_count = 0. Repeat with a key on cycle 7 → no timeout, count 2.
- Keys A, E, B in IDLE → no output change; digit_count stays 0.
